// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for bin2bcd_seq: the requester drives start/bin,
// the converter returns busy/done and the latched BCD, 7-segment and overflow results.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start_i;
  logic [BIN_W-1:0]      bin_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  ovf_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic [7*DIGITS-1:0]   seg_o;

  modport master (output start_i, bin_i, input busy_o, done_o, ovf_o, bcd_o, seg_o);
  modport slave  (input start_i, bin_i, output busy_o, done_o, ovf_o, bcd_o, seg_o);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock, with 7-seg decode.
// Define BIN2BCD_LZ_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bin2bcd_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, XFER} state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] seg_reset();
    logic [SEG_W-1:0] r;
    for (int k = 0; k < DIGITS; k++) begin
`ifdef BIN2BCD_LZ_BLANK_EN
      r[7*k +: 7] = (k == 0) ? 7'b0000001 : 7'b1111111;
`else
      r[7*k +: 7] = 7'b0000001;
`endif
    end
    return r;
  endfunction

  localparam logic [SEG_W-1:0] SEG_RST = seg_reset();

  state_t           state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;
  logic             ovf_s;
  logic [CNT_W-1:0] cnt;
  logic [SEG_W-1:0] seg_dec;

  // Add-3 correction on every digit before the shift; carries never cross digits.
  always_comb begin
    scratch_adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

`ifdef BIN2BCD_LZ_BLANK_EN
  logic lz;
  always_comb begin
    seg_dec = '0;
    lz      = 1'b1;
    // lz stays set while this digit and every more-significant one are zero.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz = lz && (scratch[4*k +: 4] == 4'd0);
      seg_dec[7*k +: 7] = (lz && k != 0) ? 7'b1111111 : seg_of(scratch[4*k +: 4]);
    end
  end
`else
  always_comb begin
    seg_dec = '0;
    for (int k = 0; k < DIGITS; k++) seg_dec[7*k +: 7] = seg_of(scratch[4*k +: 4]);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bus.busy_o  <= 1'b0;
      bus.done_o  <= 1'b0;
      bus.ovf_o   <= 1'b0;
      bus.bcd_o   <= '0;
      bus.seg_o   <= SEG_RST;
      // NOTE: scratch datapath is cleared too; reset also abandons a conversion in flight.
      bin_sr      <= '0;
      scratch     <= '0;
      ovf_s       <= 1'b0;
      cnt         <= '0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            bin_sr     <= bus.bin_i;
            scratch    <= '0;
            ovf_s      <= 1'b0;
            cnt        <= CNT_W'(BIN_W);
            bus.busy_o <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Any 1 leaving the top digit means the value needs more than DIGITS digits.
          ovf_s   <= ovf_s | scratch_adj[BCD_W-1];
          scratch <= {scratch_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
          bin_sr  <= bin_sr << 1;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= XFER;
        end
        XFER: begin
          bus.bcd_o  <= scratch;
          bus.ovf_o  <= ovf_s;
          bus.seg_o  <= seg_dec;
          bus.done_o <= 1'b1;
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboarded bench for bin2bcd_seq across four parameter sets (8/3, 16/5, 8/2, 1/1).
// Expected results come from an arithmetic (divide-by-10) model of each accepted start.
module tb_bin2bcd_seq;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] bcd;
    logic [34:0] seg;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) b0 ();
  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) b1 ();
  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) b2 ();
  bin2bcd_seq_if #(.BIN_W(1),  .DIGITS(1)) b3 ();

  bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) u_d0 (.clk_i(clk_i), .rst_i(rst_i), .bus(b0));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d1 (.clk_i(clk_i), .rst_i(rst_i), .bus(b1));
  bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) u_d2 (.clk_i(clk_i), .rst_i(rst_i), .bus(b2));
  bin2bcd_seq #(.BIN_W(1),  .DIGITS(1)) u_d3 (.clk_i(clk_i), .rst_i(rst_i), .bus(b3));

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 7'b0000001;
      4'd1: seg_code = 7'b1001111;
      4'd2: seg_code = 7'b0010010;
      4'd3: seg_code = 7'b0000110;
      4'd4: seg_code = 7'b1001100;
      4'd5: seg_code = 7'b0100100;
      4'd6: seg_code = 7'b0100000;
      4'd7: seg_code = 7'b0001111;
      4'd8: seg_code = 7'b0000000;
      4'd9: seg_code = 7'b0000100;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  function automatic logic [34:0] seg_rst(input int digits);
    logic [34:0] r = '0;
    for (int k = 0; k < digits; k++) begin
`ifdef BIN2BCD_LZ_BLANK_EN
      r[7*k +: 7] = (k == 0) ? 7'b0000001 : 7'b1111111;
`else
      r[7*k +: 7] = 7'b0000001;
`endif
    end
    return r;
  endfunction

  function automatic exp_t model(input int unsigned v, input int digits, input int acc);
    exp_t        e;
    int unsigned r = v;
    int unsigned p = 1;
    e.bcd = '0;
    e.seg = '0;
    e.acc = acc;
    for (int k = 0; k < digits; k++) p = p * 10;
    e.ovf = (v >= p);
    for (int k = 0; k < digits; k++) begin
      e.bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
`ifdef BIN2BCD_LZ_BLANK_EN
    begin
      bit lz = 1'b1;
      for (int k = digits - 1; k >= 0; k--) begin
        lz = lz && (e.bcd[4*k +: 4] == 4'd0);
        e.seg[7*k +: 7] = (lz && k != 0) ? 7'b1111111 : seg_code(e.bcd[4*k +: 4]);
      end
    end
`else
    for (int k = 0; k < digits; k++) e.seg[7*k +: 7] = seg_code(e.bcd[4*k +: 4]);
`endif
    return e;
  endfunction

  // Monitors: every done pulse must match the oldest expectation, including latency BIN_W+1.
  always @(negedge clk_i) begin
    if (b0.done_o === 1'b1) begin
      exp_t e;
      checks++;
      if (q0.size() == 0) begin
        errors++; $display("FAIL d0_unexpected_done got done=1 want no done");
      end else begin
        e = q0.pop_front();
        checks += 4;
        if (20'(b0.bcd_o) !== e.bcd) begin errors++; $display("FAIL d0_bcd got %h want %h", b0.bcd_o, e.bcd); end
        if (35'(b0.seg_o) !== e.seg) begin errors++; $display("FAIL d0_seg got %b want %b", b0.seg_o, e.seg); end
        if (b0.ovf_o !== e.ovf) begin errors++; $display("FAIL d0_ovf got %b want %b", b0.ovf_o, e.ovf); end
        if (cyc - e.acc != 9) begin errors++; $display("FAIL d0_latency got %0d want 9", cyc - e.acc); end
      end
    end
  end

  always @(negedge clk_i) begin
    if (b1.done_o === 1'b1) begin
      exp_t e;
      checks++;
      if (q1.size() == 0) begin
        errors++; $display("FAIL d1_unexpected_done got done=1 want no done");
      end else begin
        e = q1.pop_front();
        checks += 4;
        if (20'(b1.bcd_o) !== e.bcd) begin errors++; $display("FAIL d1_bcd got %h want %h", b1.bcd_o, e.bcd); end
        if (35'(b1.seg_o) !== e.seg) begin errors++; $display("FAIL d1_seg got %b want %b", b1.seg_o, e.seg); end
        if (b1.ovf_o !== e.ovf) begin errors++; $display("FAIL d1_ovf got %b want %b", b1.ovf_o, e.ovf); end
        if (cyc - e.acc != 17) begin errors++; $display("FAIL d1_latency got %0d want 17", cyc - e.acc); end
      end
    end
  end

  always @(negedge clk_i) begin
    if (b2.done_o === 1'b1) begin
      exp_t e;
      checks++;
      if (q2.size() == 0) begin
        errors++; $display("FAIL d2_unexpected_done got done=1 want no done");
      end else begin
        e = q2.pop_front();
        checks += 4;
        if (20'(b2.bcd_o) !== e.bcd) begin errors++; $display("FAIL d2_bcd got %h want %h", b2.bcd_o, e.bcd); end
        if (35'(b2.seg_o) !== e.seg) begin errors++; $display("FAIL d2_seg got %b want %b", b2.seg_o, e.seg); end
        if (b2.ovf_o !== e.ovf) begin errors++; $display("FAIL d2_ovf got %b want %b", b2.ovf_o, e.ovf); end
        if (cyc - e.acc != 9) begin errors++; $display("FAIL d2_latency got %0d want 9", cyc - e.acc); end
      end
    end
  end

  always @(negedge clk_i) begin
    if (b3.done_o === 1'b1) begin
      exp_t e;
      checks++;
      if (q3.size() == 0) begin
        errors++; $display("FAIL d3_unexpected_done got done=1 want no done");
      end else begin
        e = q3.pop_front();
        checks += 4;
        if (20'(b3.bcd_o) !== e.bcd) begin errors++; $display("FAIL d3_bcd got %h want %h", b3.bcd_o, e.bcd); end
        if (35'(b3.seg_o) !== e.seg) begin errors++; $display("FAIL d3_seg got %b want %b", b3.seg_o, e.seg); end
        if (b3.ovf_o !== e.ovf) begin errors++; $display("FAIL d3_ovf got %b want %b", b3.ovf_o, e.ovf); end
        if (cyc - e.acc != 2) begin errors++; $display("FAIL d3_latency got %0d want 2", cyc - e.acc); end
      end
    end
  end

  // Start helpers: wait (bounded) for idle, pulse start for one edge, confirm acceptance.
  task automatic start0(input int unsigned v, input bit track);
    for (int i = 0; i < 200 && b0.busy_o !== 1'b0; i++) @(negedge clk_i);
    checks++;
    if (b0.busy_o !== 1'b0) begin errors++; $display("FAIL d0_idle_wait got busy=%b want 0", b0.busy_o); end
    b0.bin_i = 8'(v); b0.start_i = 1'b1;
    @(posedge clk_i); #1;
    b0.start_i = 1'b0;
    checks++;
    if (b0.busy_o !== 1'b1) begin errors++; $display("FAIL d0_accept got busy=%b want 1", b0.busy_o); end
    if (track) q0.push_back(model(v, 3, cyc));
  endtask

  task automatic start1(input int unsigned v);
    for (int i = 0; i < 200 && b1.busy_o !== 1'b0; i++) @(negedge clk_i);
    checks++;
    if (b1.busy_o !== 1'b0) begin errors++; $display("FAIL d1_idle_wait got busy=%b want 0", b1.busy_o); end
    b1.bin_i = 16'(v); b1.start_i = 1'b1;
    @(posedge clk_i); #1;
    b1.start_i = 1'b0;
    checks++;
    if (b1.busy_o !== 1'b1) begin errors++; $display("FAIL d1_accept got busy=%b want 1", b1.busy_o); end
    q1.push_back(model(v, 5, cyc));
  endtask

  task automatic start2(input int unsigned v);
    for (int i = 0; i < 200 && b2.busy_o !== 1'b0; i++) @(negedge clk_i);
    checks++;
    if (b2.busy_o !== 1'b0) begin errors++; $display("FAIL d2_idle_wait got busy=%b want 0", b2.busy_o); end
    b2.bin_i = 8'(v); b2.start_i = 1'b1;
    @(posedge clk_i); #1;
    b2.start_i = 1'b0;
    checks++;
    if (b2.busy_o !== 1'b1) begin errors++; $display("FAIL d2_accept got busy=%b want 1", b2.busy_o); end
    q2.push_back(model(v, 2, cyc));
  endtask

  task automatic start3(input int unsigned v);
    for (int i = 0; i < 200 && b3.busy_o !== 1'b0; i++) @(negedge clk_i);
    checks++;
    if (b3.busy_o !== 1'b0) begin errors++; $display("FAIL d3_idle_wait got busy=%b want 0", b3.busy_o); end
    b3.bin_i = 1'(v); b3.start_i = 1'b1;
    @(posedge clk_i); #1;
    b3.start_i = 1'b0;
    checks++;
    if (b3.busy_o !== 1'b1) begin errors++; $display("FAIL d3_accept got busy=%b want 1", b3.busy_o); end
    q3.push_back(model(v, 1, cyc));
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk_i);
      idle = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) && (q3.size() == 0) &&
             !b0.busy_o && !b1.busy_o && !b2.busy_o && !b3.busy_o;
    end
    checks++;
    if (!idle) begin errors++; $display("FAIL drain_timeout got pending=%0d want 0", q0.size() + q1.size() + q2.size() + q3.size()); end
  endtask

  task automatic check_reset_state0(input string tag);
    checks += 5;
    if (b0.busy_o !== 1'b0) begin errors++; $display("FAIL %s_busy got %b want 0", tag, b0.busy_o); end
    if (b0.done_o !== 1'b0) begin errors++; $display("FAIL %s_done got %b want 0", tag, b0.done_o); end
    if (b0.ovf_o  !== 1'b0) begin errors++; $display("FAIL %s_ovf got %b want 0", tag, b0.ovf_o); end
    if (b0.bcd_o  !== 12'h000) begin errors++; $display("FAIL %s_bcd got %h want 000", tag, b0.bcd_o); end
    if (35'(b0.seg_o) !== seg_rst(3)) begin errors++; $display("FAIL %s_seg got %b want %b", tag, b0.seg_o, seg_rst(3)); end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state0("rst_d0");
    checks++;
    if (35'(b1.seg_o) !== seg_rst(5)) begin errors++; $display("FAIL rst_d1_seg got %b want %b", b1.seg_o, seg_rst(5)); end
    rst_i = 1'b0;
  endtask

  task automatic test_max();
    int bc = 1;
    start0(255, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_i); #1;
      if (b0.busy_o === 1'b1) bc++;
      if (k == 9) begin
        checks++;
        if (b0.done_o !== 1'b1) begin errors++; $display("FAIL max_done_edge got %b want 1", b0.done_o); end
      end
      if (k == 10) begin
        checks++;
        if (b0.done_o !== 1'b0) begin errors++; $display("FAIL max_done_pulse got %b want 0", b0.done_o); end
      end
    end
    checks++;
    if (bc != 9) begin errors++; $display("FAIL max_busy_cycles got %0d want 9", bc); end
    drain();
  endtask

  task automatic test_zero();
    start0(0, 1'b1);
    drain();
  endtask

  task automatic test_wide();
    start1(65535);
    start1(0);
    start1(10000);
    drain();
  endtask

  task automatic test_overflow();
    start2(99);
    start2(200);
    start2(100);
    start2(255);
    drain();
  endtask

  task automatic test_bw1();
    start3(1);
    start3(0);
    drain();
  endtask

  task automatic test_ignore_start();
    bit seen = 1'b0;
    start0(123, 1'b1);
    repeat (3) @(negedge clk_i);
    b0.bin_i = 8'd77; b0.start_i = 1'b1;
    @(negedge clk_i);
    b0.start_i = 1'b0; b0.bin_i = 8'd0;
    checks++;
    if (b0.busy_o !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", b0.busy_o); end
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      seen = (b0.done_o === 1'b1);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL ignore_done_timeout got no done want done"); end
    start0(77, 1'b1);
    drain();
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    start0(200, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_reset_state0("abort");
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (b0.done_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_done got done=1 want 0"); end
    // Reset and start on the same edge: reset must win.
    @(negedge clk_i);
    rst_i = 1'b1; b0.start_i = 1'b1; b0.bin_i = 8'd99;
    @(posedge clk_i); #1;
    rst_i = 1'b0; b0.start_i = 1'b0;
    checks++;
    if (b0.busy_o !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", b0.busy_o); end
    start0(42, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) start0($urandom_range(0, 255), 1'b1);
    for (int i = 0; i < 3; i++) start1($urandom_range(0, 65535));
    drain();
  endtask

  initial begin
    b0.start_i = 1'b0; b0.bin_i = '0;
    b1.start_i = 1'b0; b1.bin_i = '0;
    b2.start_i = 1'b0; b2.bin_i = '0;
    b3.start_i = 1'b0; b3.bin_i = '0;
    test_reset();
    test_max();
    test_zero();
    test_wide();
    test_overflow();
    test_bw1();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (q0.size() + q1.size() + q2.size() + q3.size() != 0) begin
      errors++; $display("FAIL leftover_expected got %0d want 0", q0.size() + q1.size() + q2.size() + q3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
